// File: rtl/ppu_timing_ctrl.sv
// NTSC PPU dot/scanline timing generator and PPUSTATUS set/clear sequencer.
// Drives VBLANK/sprite strobes, the odd-frame dot skip and the CPU NMI line.
module ppu_timing_ctrl #(
  parameter int DOTS_PER_LINE   = 341,
  parameter int LINES_PER_FRAME = 262,
  parameter int VBLANK_LINE     = 241,
  parameter int PRERENDER_LINE  = 261,
  parameter int VISIBLE_LINES   = 240,
  parameter int VISIBLE_DOTS    = 256
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Dot_En,
  input  logic       Rendering_En,
  input  logic       NMI_En,
  input  logic       Status_Rd,
  input  logic       Vblank_Flag,
  output logic       VBLANK_set,
  output logic       VBLANK_clear,
  output logic       Sprite_clear,
  output logic [8:0] Dot,
  output logic [8:0] Scanline,
  output logic       Frame_Odd,
  output logic       Visible,
  output logic       NMI_n
);

  localparam logic [8:0] LAST_DOT  = 9'(DOTS_PER_LINE - 1);
  localparam logic [8:0] SKIP_DOT  = 9'(DOTS_PER_LINE - 2);
  localparam logic [8:0] LAST_LINE = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] VB_LINE   = 9'(VBLANK_LINE);
  localparam logic [8:0] PRE_LINE  = 9'(PRERENDER_LINE);
  localparam logic [8:0] VIS_LINES = 9'(VISIBLE_LINES);
  localparam logic [8:0] VIS_DOTS  = 9'(VISIBLE_DOTS);

  logic [8:0] dot_q, dot_d;
  logic [8:0] line_q, line_d;
  logic       odd_q, odd_d;
  logic       vset_q, vset_d;
  logic       vclr_q, vclr_d;
  logic       suppress_q, suppress_d;
  logic       visible_q, visible_d;
  logic       nmi_n_q, nmi_n_d;
  logic       at_vblank, at_prerender, odd_skip;

  always_comb begin
    dot_d        = dot_q;
    line_d       = line_q;
    odd_d        = odd_q;
    at_vblank    = (line_q == VB_LINE) && (dot_q == 9'd0);
    at_prerender = (line_q == PRE_LINE) && (dot_q == 9'd0);
    odd_skip     = Dot_En && Rendering_En && odd_q &&
                   (line_q == LAST_LINE) && (dot_q == SKIP_DOT);

    if (odd_skip) begin
      dot_d  = 9'd0;
      line_d = 9'd0;
      odd_d  = ~odd_q;
    end else if (Dot_En) begin
      if (dot_q == LAST_DOT) begin
        dot_d = 9'd0;
        if (line_q == LAST_LINE) begin
          line_d = 9'd0;
          odd_d  = ~odd_q;
        end else begin
          line_d = line_q + 9'd1;
        end
      end else begin
        dot_d = dot_q + 9'd1;
      end
    end

    // A $2002 read on the edge leaving (VBLANK_LINE,0) swallows this frame's set
    vset_d = Dot_En && at_vblank && !Status_Rd;
    vclr_d = Dot_En && at_prerender;

    suppress_d = suppress_q;
    if (vclr_d) begin
      suppress_d = 1'b0;
    end else if ((Dot_En && at_vblank && Status_Rd) || (Status_Rd && vset_q)) begin
      suppress_d = 1'b1;
    end

    visible_d = (line_d < VIS_LINES) && (dot_d != 9'd0) && (dot_d <= VIS_DOTS);
    nmi_n_d   = ~(Vblank_Flag & NMI_En & ~suppress_q);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      dot_q      <= 9'd0;
      line_q     <= 9'd0;
      odd_q      <= 1'b0;
      vset_q     <= 1'b0;
      vclr_q     <= 1'b0;
      suppress_q <= 1'b0;
      visible_q  <= 1'b0;
      nmi_n_q    <= 1'b1;
    end else begin
      dot_q      <= dot_d;
      line_q     <= line_d;
      odd_q      <= odd_d;
      vset_q     <= vset_d;
      vclr_q     <= vclr_d;
      suppress_q <= suppress_d;
      visible_q  <= visible_d;
      nmi_n_q    <= nmi_n_d;
    end
  end

  assign Dot          = dot_q;
  assign Scanline     = line_q;
  assign Frame_Odd    = odd_q;
  assign VBLANK_set   = vset_q;
  assign VBLANK_clear = vclr_q;
  assign Sprite_clear = vclr_q;
  assign Visible      = visible_q;
  assign NMI_n        = nmi_n_q;

endmodule
